// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage ALU.
// Opcodes 0-10 complete in a single cycle. MUL runs a 32-step shift-add and
// DIVU/REMU run 32-step restoring division, each followed by one DONE cycle
// that loads the output register. busy stalls the ID/EX register whenever
// the FSM is not IDLE. flush aborts any operation in flight.
module ex_alu_unit #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int ALU_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ALU_W-1:0]  alu_type,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2_imm,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              write_tag_in,
    input  logic              flush,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic [REG_W-1:0]  rd,
    output logic              write_alu_result_tag
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [ALU_W-1:0] OP_NOP  = ALU_W'(4'd0);
    localparam logic [ALU_W-1:0] OP_ADD  = ALU_W'(4'd1);
    localparam logic [ALU_W-1:0] OP_SUB  = ALU_W'(4'd2);
    localparam logic [ALU_W-1:0] OP_AND  = ALU_W'(4'd3);
    localparam logic [ALU_W-1:0] OP_OR   = ALU_W'(4'd4);
    localparam logic [ALU_W-1:0] OP_XOR  = ALU_W'(4'd5);
    localparam logic [ALU_W-1:0] OP_SLL  = ALU_W'(4'd6);
    localparam logic [ALU_W-1:0] OP_SRL  = ALU_W'(4'd7);
    localparam logic [ALU_W-1:0] OP_SRA  = ALU_W'(4'd8);
    localparam logic [ALU_W-1:0] OP_SLT  = ALU_W'(4'd9);
    localparam logic [ALU_W-1:0] OP_SLTU = ALU_W'(4'd10);
    localparam logic [ALU_W-1:0] OP_MUL  = ALU_W'(4'd11);
    localparam logic [ALU_W-1:0] OP_DIVU = ALU_W'(4'd12);
    localparam logic [ALU_W-1:0] OP_REMU = ALU_W'(4'd13);

    // Last iteration index; the counter reaches it on the final iterative edge.
    localparam logic [5:0] CNT_LAST = 6'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Single-cycle operations; NOP and reserved codes give zero.
    function automatic logic [DATA_W-1:0] alu_simple(
        input logic [ALU_W-1:0]  op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [SH_W-1:0] sh;
        sh = b[SH_W-1:0];
        case (op)
            OP_ADD:  alu_simple = a + b;
            OP_SUB:  alu_simple = a - b;
            OP_AND:  alu_simple = a & b;
            OP_OR:   alu_simple = a | b;
            OP_XOR:  alu_simple = a ^ b;
            OP_SLL:  alu_simple = a << sh;
            OP_SRL:  alu_simple = a >> sh;
            OP_SRA:  alu_simple = $signed(a) >>> sh;
            OP_SLT:  alu_simple = ($signed(a) < $signed(b)) ? DATA_W'(1'b1) : {DATA_W{1'b0}};
            OP_SLTU: alu_simple = (a < b) ? DATA_W'(1'b1) : {DATA_W{1'b0}};
            default: alu_simple = {DATA_W{1'b0}};
        endcase
    endfunction

    // True for opcodes that are allowed to write the register file.
    function automatic logic writes_reg(input logic [ALU_W-1:0] op);
        writes_reg = (op >= OP_ADD) && (op <= OP_REMU);
    endfunction

    state_t              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [ALU_W-1:0]    op_q, op_d;
    logic [REG_W-1:0]    rd_lat_q, rd_lat_d;
    logic                tag_lat_q, tag_lat_d;
    // opa: multiplicand (MUL) or divisor (DIV)
    // opb: multiplier (MUL) or dividend shifting into quotient (DIV)
    // acc: product (MUL) or partial remainder (DIV)
    logic [DATA_W-1:0]   opa_q, opa_d;
    logic [DATA_W-1:0]   opb_q, opb_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [REG_W-1:0]    rd_q, rd_d;
    logic                wtag_q, wtag_d;

    logic [DATA_W:0]     rem_shift_s;
    logic [DATA_W:0]     rem_diff_s;

    // Restoring-division trial: shift next dividend bit into the remainder, subtract divisor.
    assign rem_shift_s = {acc_q, opb_q[DATA_W-1]};
    assign rem_diff_s  = rem_shift_s - {1'b0, opa_q};

    // Next-state, datapath and output-register load logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        rd_lat_d    = rd_lat_q;
        tag_lat_d   = tag_lat_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        rd_d        = rd_q;
        wtag_d      = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d      = alu_type;
                        rd_lat_d  = rd_in;
                        tag_lat_d = write_tag_in;
                        cnt_d     = 6'd0;
                        case (alu_type)
                            OP_MUL: begin
                                opa_d   = src1;
                                opb_d   = src2_imm;
                                acc_d   = {DATA_W{1'b0}};
                                state_d = ST_MUL;
                            end
                            OP_DIVU, OP_REMU: begin
                                opa_d = src2_imm;
                                acc_d = {DATA_W{1'b0}};
                                if (src2_imm == {DATA_W{1'b0}}) begin
                                    // Divide by zero: quotient all-ones, remainder dividend.
                                    opb_d   = {DATA_W{1'b1}};
                                    acc_d   = src1;
                                    state_d = ST_DONE;
                                end else begin
                                    opb_d   = src1;
                                    state_d = ST_DIV;
                                end
                            end
                            default: begin
                                out_valid_d = 1'b1;
                                result_d    = alu_simple(alu_type, src1, src2_imm);
                                rd_d        = rd_in;
                                wtag_d      = write_tag_in & writes_reg(alu_type);
                            end
                        endcase
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL: begin
                    if (opb_q[0]) begin
                        acc_d = acc_q + opa_q;
                    end else begin
                        acc_d = acc_q;
                    end
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
                ST_DIV: begin
                    if (!rem_diff_s[DATA_W]) begin
                        acc_d = rem_diff_s[DATA_W-1:0];
                        opb_d = {opb_q[DATA_W-2:0], 1'b1};
                    end else begin
                        acc_d = rem_shift_s[DATA_W-1:0];
                        opb_d = {opb_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
                ST_DONE: begin
                    out_valid_d = 1'b1;
                    rd_d        = rd_lat_q;
                    wtag_d      = tag_lat_q;
                    if (op_q == OP_DIVU) begin
                        result_d = opb_q;
                    end else begin
                        result_d = acc_q;
                    end
                    cnt_d   = 6'd0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 6'd0;
                end
            endcase
        end
    end

    // State, operand latches and output register; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 6'd0;
            op_q        <= OP_NOP;
            rd_lat_q    <= {REG_W{1'b0}};
            tag_lat_q   <= 1'b0;
            opa_q       <= {DATA_W{1'b0}};
            opb_q       <= {DATA_W{1'b0}};
            acc_q       <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            result_q    <= {DATA_W{1'b0}};
            rd_q        <= {REG_W{1'b0}};
            wtag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            rd_lat_q    <= rd_lat_d;
            tag_lat_q   <= tag_lat_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            wtag_q      <= wtag_d;
        end
    end

    assign busy                 = (state_q != ST_IDLE);
    assign out_valid            = out_valid_q;
    assign result               = result_q;
    assign rd                   = rd_q;
    assign write_alu_result_tag = wtag_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed bench for ex_alu_unit: single-cycle ops, MUL/DIVU/REMU timing,
// divide by zero, flush and asynchronous reset mid-operation.
module tb_ex_alu_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  alu_type;
    logic [31:0] src1;
    logic [31:0] src2_imm;
    logic [4:0]  rd_in;
    logic        write_tag_in;
    logic        flush;
    logic        busy;
    logic        out_valid;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        write_alu_result_tag;

    int checks   = 0;
    int failures = 0;
    int cyc;
    int spur;

    ex_alu_unit #(.DATA_W(32), .REG_W(5), .ALU_W(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .alu_type             (alu_type),
        .src1                 (src1),
        .src2_imm             (src2_imm),
        .rd_in                (rd_in),
        .write_tag_in         (write_tag_in),
        .flush                (flush),
        .busy                 (busy),
        .out_valid            (out_valid),
        .result               (result),
        .rd                   (rd),
        .write_alu_result_tag (write_alu_result_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one entry for one edge, then drop in_valid; returns #1 after the edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic t);
        alu_type     = op;
        src1         = a;
        src2_imm     = b;
        rd_in        = r;
        write_tag_in = t;
        in_valid     = 1'b1;
        @(posedge clk); #1;
        in_valid     = 1'b0;
    endtask

    // Output register after a load.
    task automatic check_load(input string tag, input logic [31:0] res,
                              input logic [4:0] r, input logic t);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_result"}, result, res);
        check({tag, "_rd"}, {27'd0, rd}, {27'd0, r});
        check({tag, "_tag"}, {31'd0, write_alu_result_tag}, {31'd0, t});
    endtask

    // Counts edges after the accept edge until busy drops (bounded); pokes
    // in_valid once mid-operation, which must be ignored.
    task automatic wait_done(output int n, output int sp);
        n  = 0;
        sp = 0;
        while (busy && n < 100) begin
            in_valid = (n == 5);
            if (out_valid) sp++;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; alu_type = 4'd0;
        src1 = 32'd0; src2_imm = 32'd0; rd_in = 5'd0; write_tag_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", {27'd0, rd}, 32'd0);
        check("rst_tag", {31'd0, write_alu_result_tag}, 32'd0);

        // First edge after release accepts ADD with wraparound.
        @(negedge clk); rst = 1'b0;
        issue(4'd1, 32'hFFFF_FFFF, 32'd2, 5'd7, 1'b1);
        check_load("add_wrap", 32'h0000_0001, 5'd7, 1'b1);
        @(posedge clk); #1;
        check("add_pulse_end", {31'd0, out_valid}, 32'd0);
        check("add_tag_end", {31'd0, write_alu_result_tag}, 32'd0);
        check("add_result_hold", result, 32'h0000_0001);
        check("add_rd_hold", {27'd0, rd}, 32'd7);

        issue(4'd8, 32'h8000_0000, 32'h0000_0024, 5'd3, 1'b1);
        check_load("sra", 32'hF800_0000, 5'd3, 1'b1);
        issue(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
        check_load("slt", 32'd1, 5'd4, 1'b1);
        issue(4'd10, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
        check_load("sltu", 32'd0, 5'd5, 1'b1);
        issue(4'd2, 32'd3, 32'd5, 5'd6, 1'b0);
        check_load("sub", 32'hFFFF_FFFE, 5'd6, 1'b0);
        issue(4'd6, 32'd1, 32'h0000_0021, 5'd8, 1'b1);
        check_load("sll", 32'd2, 5'd8, 1'b1);
        issue(4'd7, 32'h8000_0000, 32'd31, 5'd9, 1'b1);
        check_load("srl", 32'd1, 5'd9, 1'b1);
        issue(4'd5, 32'h0000_F0F0, 32'h0000_FF00, 5'd10, 1'b1);
        check_load("xor", 32'h0000_0FF0, 5'd10, 1'b1);
        issue(4'd3, 32'h0000_F0F0, 32'h0000_FF00, 5'd11, 1'b1);
        check_load("and", 32'h0000_F000, 5'd11, 1'b1);
        issue(4'd4, 32'h0000_F0F0, 32'h0000_FF00, 5'd12, 1'b1);
        check_load("or", 32'h0000_FFF0, 5'd12, 1'b1);
        issue(4'd0, 32'd9, 32'd9, 5'd13, 1'b1);
        check_load("nop", 32'd0, 5'd13, 1'b0);
        issue(4'd14, 32'd9, 32'd9, 5'd14, 1'b1);
        check_load("rsvd", 32'd0, 5'd14, 1'b0);

        // MUL: 33 busy cycles, single pulse, ignored in_valid mid-operation.
        issue(4'd11, 32'h0001_0001, 32'h0001_0001, 5'd15, 1'b1);
        check("mul_busy_e0", {31'd0, busy}, 32'd1);
        check("mul_no_early", {31'd0, out_valid}, 32'd0);
        wait_done(cyc, spur);
        check("mul_cycles", cyc, 32'd33);
        check("mul_spurious", spur, 32'd0);
        check_load("mul", 32'h0002_0001, 5'd15, 1'b1);
        @(posedge clk); #1;
        check("mul_pulse_end", {31'd0, out_valid}, 32'd0);
        check("mul_ignored_busy", {31'd0, busy}, 32'd0);

        issue(4'd12, 32'd100, 32'd7, 5'd16, 1'b1);
        wait_done(cyc, spur);
        check("divu_cycles", cyc, 32'd33);
        check_load("divu", 32'd14, 5'd16, 1'b1);
        issue(4'd13, 32'd100, 32'd7, 5'd17, 1'b1);
        wait_done(cyc, spur);
        check("remu_cycles", cyc, 32'd33);
        check_load("remu", 32'd2, 5'd17, 1'b1);

        // Divide by zero: DONE at E0, load at E1.
        issue(4'd12, 32'd5, 32'd0, 5'd18, 1'b1);
        check("divz_busy_e0", {31'd0, busy}, 32'd1);
        wait_done(cyc, spur);
        check("divz_cycles", cyc, 32'd1);
        check_load("divz", 32'hFFFF_FFFF, 5'd18, 1'b1);
        issue(4'd13, 32'd5, 32'd0, 5'd19, 1'b1);
        wait_done(cyc, spur);
        check("remz_cycles", cyc, 32'd1);
        check_load("remz", 32'd5, 5'd19, 1'b1);

        // Flush at E10 of a MUL, then ADD at E11.
        issue(4'd11, 32'd3, 32'd4, 5'd20, 1'b1);
        repeat (9) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        issue(4'd1, 32'd10, 32'd20, 5'd21, 1'b1);
        check_load("post_flush_add", 32'd30, 5'd21, 1'b1);

        // Flush beats accept on the same edge.
        flush = 1'b1;
        issue(4'd11, 32'd3, 32'd4, 5'd22, 1'b1);
        flush = 1'b0;
        check("flush_prio_busy", {31'd0, busy}, 32'd0);
        check("flush_prio_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-DIVU.
        issue(4'd12, 32'd100, 32'd7, 5'd23, 1'b1);
        repeat (14) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_result", result, 32'd0);
        check("mrst_rd", {27'd0, rd}, 32'd0);
        check("mrst_tag", {31'd0, write_alu_result_tag}, 32'd0);
        @(negedge clk); rst = 1'b0;
        issue(4'd1, 32'd1, 32'd1, 5'd24, 1'b1);
        check_load("post_rst_add", 32'd2, 5'd24, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
